// File: rtl/div_issue_queue.sv
// div_issue_queue: request FIFO, divider slot tagging and in-order result
// collection for a 16/8 unsigned serial divider.
module div_issue_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_sys,
    input  logic                      reset_sys,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [15:0]               s_divident,
    input  logic [7:0]                s_divisor,
    input  logic                      div_in_valid,
    input  logic                      div_out_valid,
    input  logic [15:0]               div_q,
    input  logic [7:0]                div_remain,
    output logic [15:0]               div_divident,
    output logic [7:0]                div_divisor,
    output logic                      div_reset_sync,
    output logic                      m_valid,
    output logic [15:0]               m_q,
    output logic [7:0]                m_remain,
    output logic                      m_div_zero,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned DVD_W = 16;
    localparam int unsigned DVS_W = 8;

    // One queued request.
    typedef struct packed {
        logic [DVD_W-1:0] divident;
        logic [DVS_W-1:0] divisor;
    } req_t;

    // Per-slot tag: whether the slot carries a real request, and whether its divisor is zero.
    typedef struct packed {
        logic is_real;
        logic zero;
    } tag_t;

    req_t             mem [DEPTH];
    req_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    tag_t [1:0]       tags;
    logic             wr_en;
    logic             rd_en;
    logic             not_empty;
    logic             collect;

    // Handshake and issue decisions; flush overrides both.
    always_comb begin
        not_empty = (level != '0);
        s_ready   = (level != LVL_W'(DEPTH));
        wr_en     = s_valid && s_ready && !flush;
        rd_en     = div_in_valid && not_empty && !flush;
        collect   = div_out_valid && tags[1].is_real && !flush;
    end

    // Head of the queue presented to the divider, zero while empty.
    always_comb begin
        head         = mem[rd_ptr];
        div_divident = '0;
        div_divisor  = '0;
        if (not_empty) begin
            div_divident = head.divident;
            div_divisor  = head.divisor;
        end
    end

    // Queue storage; contents need no reset, validity is tracked by level.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_divident, s_divisor};
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Slot tags follow the divider's sampling strobe; tags[1] is the slot whose result is next.
    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            tags <= '0;
        end else if (flush) begin
            tags <= '0;
        end else if (div_in_valid) begin
            tags[1] <= tags[0];
            tags[0] <= tag_t'{is_real: rd_en, zero: (div_divisor == '0)};
        end
    end

    // Result capture: only real slots produce a pulse; data holds between pulses.
    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            m_valid    <= 1'b0;
            m_q        <= '0;
            m_remain   <= '0;
            m_div_zero <= 1'b0;
        end else if (flush) begin
            m_valid    <= 1'b0;
            m_q        <= '0;
            m_remain   <= '0;
            m_div_zero <= 1'b0;
        end else begin
            m_valid <= collect;
            if (collect) begin
                m_q        <= div_q;
                m_remain   <= div_remain;
                m_div_zero <= tags[1].zero;
            end
        end
    end

    // Divider reset: asserted through reset and for the one cycle after a flush.
    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys) begin
            div_reset_sync <= 1'b1;
        end else begin
            div_reset_sync <= flush;
        end
    end

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: behavioural serial divider, queue/latency model,
// directed spec scenarios and randomized traffic with flushes and a reset.
module tb_div_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk_sys = 1'b0;
    logic          reset_sys;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_divident;
    logic [7:0]    s_divisor;
    logic          div_in_valid;
    logic          div_out_valid;
    logic [15:0]   div_q;
    logic [7:0]    div_remain;
    logic [15:0]   div_divident;
    logic [7:0]    div_divisor;
    logic          div_reset_sync;
    logic          m_valid;
    logic [15:0]   m_q;
    logic [7:0]    m_remain;
    logic          m_div_zero;
    logic [LW-1:0] level;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    div_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset_sys(reset_sys), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_divident(s_divident), .s_divisor(s_divisor),
        .div_in_valid(div_in_valid), .div_out_valid(div_out_valid), .div_q(div_q),
        .div_remain(div_remain), .div_divident(div_divident), .div_divisor(div_divisor),
        .div_reset_sync(div_reset_sync), .m_valid(m_valid), .m_q(m_q), .m_remain(m_remain),
        .m_div_zero(m_div_zero), .level(level)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 16'hFFFF : 16'(a / {8'd0, b});
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? a[7:0] : 8'(a % {8'd0, b});
    endfunction

    // Behavioural 16-cycle serial divider: samples on cnt==0, reports the
    // previous round's result on cnt==1 (17 cycles after sampling).
    logic [3:0]  dcnt;
    logic        started;
    logic        res_v;
    logic [15:0] a_l;
    logic [7:0]  b_l;

    always_ff @(posedge clk_sys or posedge reset_sys) begin
        if (reset_sys || div_reset_sync) begin
            dcnt    <= 4'd0;
            started <= 1'b0;
            res_v   <= 1'b0;
            a_l     <= 16'd0;
            b_l     <= 8'd0;
            div_q      <= 16'd0;
            div_remain <= 8'd0;
        end else begin
            dcnt <= dcnt + 4'd1;
            if (dcnt == 4'd0) begin
                res_v <= started;
                if (started) begin
                    div_q      <= ref_q(a_l, b_l);
                    div_remain <= ref_r(a_l, b_l);
                end
                a_l     <= div_divident;
                b_l     <= div_divisor;
                started <= 1'b1;
            end
        end
    end

    assign div_in_valid  = (dcnt == 4'd0);
    assign div_out_valid = (dcnt == 4'd1) && res_v;

    // Reference model: waiting requests, and issued requests with the cycle their pulse is due.
    typedef struct { logic [15:0] a; logic [7:0] b; } req_t;
    typedef struct { logic [15:0] a; logic [7:0] b; int emit; } fl_t;

    req_t        pend[$];
    fl_t         infl[$];
    int          cyc = 0;
    logic        e_mv, e_mz, e_rs;
    logic [15:0] e_mq;
    logic [7:0]  e_mr;

    always @(negedge clk_sys) begin
        int   sz;
        req_t r;
        fl_t  f;
        if (reset_sys) begin
            pend.delete();
            infl.delete();
            e_mv = 0; e_mq = 0; e_mr = 0; e_mz = 0; e_rs = 1;
        end
        chk("level", 32'(level), 32'(pend.size()));
        chk("s_ready", 32'(s_ready), 32'(pend.size() != DEPTH));
        chk("div_divident", 32'(div_divident), (pend.size() > 0) ? 32'(pend[0].a) : 32'd0);
        chk("div_divisor", 32'(div_divisor), (pend.size() > 0) ? 32'(pend[0].b) : 32'd0);
        chk("div_reset_sync", 32'(div_reset_sync), 32'(e_rs));
        chk("m_valid", 32'(m_valid), 32'(e_mv));
        chk("m_q", 32'(m_q), 32'(e_mq));
        chk("m_remain", 32'(m_remain), 32'(e_mr));
        chk("m_div_zero", 32'(m_div_zero), 32'(e_mz));
        if (!reset_sys) begin
            sz = pend.size();
            if (flush) begin
                pend.delete();
                infl.delete();
                e_mv = 0; e_mq = 0; e_mr = 0; e_mz = 0;
            end else begin
                e_mv = 0;
                if (infl.size() > 0 && infl[0].emit == cyc + 1) begin
                    f    = infl.pop_front();
                    e_mv = 1;
                    e_mq = ref_q(f.a, f.b);
                    e_mr = ref_r(f.a, f.b);
                    e_mz = (f.b == 8'd0);
                end
                if (div_in_valid && sz > 0) begin
                    r      = pend.pop_front();
                    f.a    = r.a;
                    f.b    = r.b;
                    f.emit = cyc + 18;
                    infl.push_back(f);
                end
                if (s_valid && sz < DEPTH) begin
                    r.a = s_divident;
                    r.b = s_divisor;
                    pend.push_back(r);
                end
            end
            e_rs = flush;
        end
        cyc++;
    end

    // Stimulus tasks: all are entered and left just after a rising edge.
    task automatic send(input logic [15:0] a, input logic [7:0] b);
        bit ok = 0;
        s_valid = 1; s_divident = a; s_divisor = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (s_ready) begin ok = 1; break; end
            @(posedge clk_sys); #1;
        end
        chk("send accepted", 32'(ok), 32'd1);
        @(posedge clk_sys); #1;
        s_valid = 0;
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        for (int i = 0; i < 40; i++) begin
            if (dcnt == v) return;
            @(posedge clk_sys); #1;
        end
        chk("wait_cnt reached", 32'(dcnt), 32'(v));
    endtask

    task automatic expect_result(input string nm, input logic [15:0] q, input logic [7:0] r,
                                 input logic z, output int waited);
        bit got = 0;
        waited = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk_sys);
            if (m_valid) begin got = 1; waited = i; break; end
        end
        chk({nm, " seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, " q"}, 32'(m_q), 32'(q));
            chk({nm, " r"}, 32'(m_remain), 32'(r));
            chk({nm, " zero"}, 32'(m_div_zero), 32'(z));
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            if (m_valid) pulses++;
        end
        @(posedge clk_sys); #1;
    endtask

    initial begin
        int w;
        int p;
        bit ok;
        reset_sys = 1; flush = 0; s_valid = 0; s_divident = 0; s_divisor = 0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("reset level", 32'(level), 32'd0);
        chk("reset s_ready", 32'(s_ready), 32'd1);
        chk("reset div_reset_sync", 32'(div_reset_sync), 32'd1);
        chk("reset m_valid", 32'(m_valid), 32'd0);
        @(posedge clk_sys); #1;
        reset_sys = 0;
        repeat (3) begin @(posedge clk_sys); #1; end

        // Single request with latency measured from the issuing strobe.
        send(16'd1000, 8'd7);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (div_in_valid && level != '0) begin ok = 1; break; end
        end
        chk("single issued", 32'(ok), 32'd1);
        expect_result("1000/7", 16'd142, 8'd6, 1'b0, w);
        chk("issue to m_valid latency", 32'(w), 32'd18);

        // Burst of five into a four-deep queue.
        wait_cnt(4'd1);
        send(16'd65535, 8'd255);
        send(16'd100, 8'd3);
        send(16'd7, 8'd9);
        send(16'd255, 8'd16);
        @(negedge clk_sys);
        chk("burst full level", 32'(level), 32'd4);
        chk("burst full s_ready", 32'(s_ready), 32'd0);
        @(posedge clk_sys); #1;
        send(16'd40000, 8'd200);
        expect_result("65535/255", 16'd257, 8'd0, 1'b0, w);
        expect_result("100/3", 16'd33, 8'd1, 1'b0, w);
        chk("burst spacing", 32'(w), 32'd16);
        expect_result("7/9", 16'd0, 8'd7, 1'b0, w);
        expect_result("255/16", 16'd15, 8'd15, 1'b0, w);
        expect_result("40000/200", 16'd200, 8'd0, 1'b0, w);

        // Divide by zero followed by a normal request.
        send(16'd100, 8'd0);
        send(16'd50, 8'd5);
        expect_result("100/0", 16'hFFFF, 8'd100, 1'b1, w);
        expect_result("50/5", 16'd10, 8'd0, 1'b0, w);

        // Idle divider rounds.
        count_pulses(48, p);
        chk("idle pulses", 32'(p), 32'd0);
        send(16'd9, 8'd2);
        expect_result("9/2", 16'd4, 8'd1, 1'b0, w);

        // Write and pop in the same cycle at level 1.
        wait_cnt(4'd1);
        send(16'd11, 8'd3);
        wait_cnt(4'd0);
        s_valid = 1; s_divident = 16'd200; s_divisor = 8'd7;
        @(negedge clk_sys);
        chk("wr+pop before level", 32'(level), 32'd1);
        chk("wr+pop head", 32'(div_divident), 32'd11);
        @(posedge clk_sys); #1;
        s_valid = 0;
        @(negedge clk_sys);
        chk("wr+pop after level", 32'(level), 32'd1);
        chk("wr+pop new head", 32'(div_divident), 32'd200);
        @(posedge clk_sys); #1;
        expect_result("11/3", 16'd3, 8'd2, 1'b0, w);
        expect_result("200/7", 16'd28, 8'd4, 1'b0, w);

        // Flush with one request in flight and two queued.
        wait_cnt(4'd15);
        send(16'd300, 8'd4);
        send(16'd1000, 8'd3);
        send(16'd77, 8'd7);
        wait_cnt(4'd5);
        flush = 1;
        @(posedge clk_sys); #1;
        flush = 0;
        @(negedge clk_sys);
        chk("flush level", 32'(level), 32'd0);
        chk("flush reset_sync high", 32'(div_reset_sync), 32'd1);
        @(negedge clk_sys);
        chk("flush reset_sync low", 32'(div_reset_sync), 32'd0);
        count_pulses(60, p);
        chk("flush pulses", 32'(p), 32'd0);
        send(16'd300, 8'd4);
        expect_result("300/4", 16'd75, 8'd0, 1'b0, w);

        // Randomized traffic with rare flushes and one reset.
        for (int i = 0; i < 700; i++) begin
            reset_sys  = (i == 350 || i == 351);
            flush      = ($urandom_range(0, 249) == 0);
            s_valid    = ($urandom_range(0, 9) < 2);
            s_divident = 16'($urandom);
            s_divisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            @(posedge clk_sys); #1;
        end
        reset_sys = 0; flush = 0; s_valid = 0;
        repeat (120) begin @(posedge clk_sys); #1; end
        chk("drain queue empty", 32'(pend.size()), 32'd0);
        chk("drain inflight empty", 32'(infl.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_issue_queue.md
# div_issue_queue

Request queue and result collector for the 16/8 unsigned serial divider. Accepts (dividend, divisor) pairs from an arbitrary-rate producer with a valid/ready handshake. Buffers them in a small FIFO and issues one pair per divider slot, exactly on the divider's input-sampling cycle. Tags each slot so that only results of real requests are forwarded downstream, in order, with a divide-by-zero flag.

## Interface
- DEPTH, 4, FIFO entries (power of two, 2..16)
- clk_sys  in  1  system clock
- reset_sys  in  1  asynchronous reset, active-high
- flush  in  1  synchronous clear of queue, slot tags and divider (active-high, one cycle)
- s_valid  in  1  request valid
- s_ready  out  1  queue can accept (not full)
- s_divident  in  16  dividend
- s_divisor  in  8  divisor
- div_in_valid  in  1  divider sampling strobe (high on divider cnt==0)
- div_out_valid  in  1  divider result strobe
- div_q  in  16  divider quotient
- div_remain  in  8  divider remainder
- div_divident  out  16  dividend presented to divider (FIFO head, 0 when empty)
- div_divisor  out  8  divisor presented to divider (FIFO head, 0 when empty)
- div_reset_sync  out  1  synchronous reset to divider
- m_valid  out  1  one-cycle result pulse (no backpressure)
- m_q  out  16  quotient
- m_remain  out  8  remainder
- m_div_zero  out  1  result came from divisor == 0
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: write on s_valid && s_ready; s_ready = (level != DEPTH). Head is shown combinationally on div_divident/div_divisor.
- Issue: on a cycle with div_in_valid && level != 0, the head is popped. The divider latches it on the same edge.
- A write and a pop in the same cycle leave level unchanged. When full, a write is refused (s_ready=0) even if a pop occurs that cycle.
- Slot tags: a 2-entry shift register of {real, zero}, shifted on every div_in_valid. Bit 0 gets {issued, head divisor==0}; bit 1 holds the previous slot.
- Collect: on div_out_valid, if tag[1].real, the block registers div_q, div_remain and tag[1].zero into the m_* outputs and pulses m_valid next cycle. Non-real slots produce no m_valid.
- Divide by zero: m_q = 16'hFFFF, m_remain = dividend[7:0] as produced by the divider, m_div_zero = 1. Values pass through unmodified.
- m_q/m_remain hold the last result between pulses.
- flush: the following are all cleared on the next edge:
  - FIFO pointers and level
  - slot tags
  - m_valid, m_q, m_remain, m_div_zero

  div_reset_sync is a registered copy of flush: high exactly one cycle, the cycle after flush. It resets the divider counter, so the first divider round after flush yields no out_valid.
- flush has priority over simultaneous write, pop or collect.

## Timing
- Reset (reset_sys high): FIFO empty, level=0, s_ready=1, tags=0, div_reset_sync=1 (held until the first edge after reset release, then 0), m_valid=0, m_q=0, m_remain=0, m_div_zero=0, div_divident=0, div_divisor=0.
- Write-to-eligible: an entry written at edge E can be issued at the first div_in_valid strictly after E.
- Issue cycle T (div_in_valid, pop): divider out_valid at T+17; m_valid high during T+18 only.
- Throughput: one result per 16 cycles; the queue absorbs bursts up to DEPTH.
- Reset or flush mid-computation: in-flight results are discarded (tag cleared), never emitted.
- Ordering: results leave in acceptance order. Exactly one m_valid is produced per accepted request, absent a flush or reset.

## Test plan
- Single request 1000/7 into an empty queue, divider free-running -> one m_valid 18 cycles after the issuing div_in_valid, with m_q=142, m_remain=6, m_div_zero=0.
- Burst of 5 requests back-to-back, DEPTH=4 -> s_ready drops after 4 accepts and recovers after the first pop. Results come out in order, 16 cycles apart:
  - 65535/255 -> 257 r 0
  - 100/3 -> 33 r 1
  - 7/9 -> 0 r 7
  - 255/16 -> 15 r 15
  - 40000/200 -> 200 r 0
- Divide by zero: 100/0 -> m_div_zero=1, m_q=16'hFFFF; the next request 50/5 -> 10 r 0 with m_div_zero=0.
- Idle slots: no requests for 3 divider rounds -> no m_valid. Then 9/2 -> exactly one m_valid, with 4 r 1.
- Simultaneous write and pop at level 1 -> level stays 1 and the popped and written data are both correct. Write attempt while full on a pop cycle -> refused.
- flush asserted 5 cycles after issuing 300/4 with 2 entries queued -> level=0, no m_valid for the in-flight or queued requests, div_reset_sync is a single-cycle pulse. A new 300/4 afterwards -> 75 r 0.
